multi_cycle_ctrl: RTL

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl_pkg.sv | 35 +++
 rtl/mc_ctrl_decode.sv | 100 ++++++++++
 rtl/multi_cycle_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared constants for the multi-cycle controller: opcodes, FSM state codes, ALU func selects.
// Used by the controller top, its strobe decoder and the testbench.
// Defines no logic; the one helper function tells executable opcodes apart from undefined ones.
package multi_cycle_ctrl_pkg;

  // Instruction opcodes (i_code)
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_LW   = 6'h02;
  localparam logic [5:0] OP_SW   = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h05;
  localparam logic [5:0] OP_HALT = 6'h3F;

  // ALU function select codes (func_sel)
  localparam logic [1:0] FUNC_IR  = 2'b00;  // use the instruction func field
  localparam logic [1:0] FUNC_ADD = 2'b01;
  localparam logic [1:0] FUNC_SUB = 2'b10;

  // FSM state codes; 6 and 7 are unused and treated as corruption
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Opcodes that have an EXEC behaviour (OP_HALT is deliberately excluded)
  function automatic logic op_is_exec(input logic [5:0] op);
    return op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Purpose: combinational decode of (registered state, registered opcode) into datapath strobes.
// Latency: zero cycles (pure decode); mem_ready/zero/fetch_go only qualify strobes in MEM/EXEC/FETCH.
// Backpressure: none here; MEM waiting is expressed by the caller holding state in ST_MEM.
// Ports: en (all outputs forced to 0 when low), cur_state, op, zero, mem_ready, fetch_go in;
//        pc_write, ir_write, pc_sel, ext_sel, reg_i_w_enable, reg_k_sel, reg_i_sel,
//        alu_k_sel, ram_w_enable, func_sel[1:0], halted out.
module mc_ctrl_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic       en,
  input  state_t     cur_state,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       fetch_go,
  output logic       pc_write,
  output logic       ir_write,
  output logic       pc_sel,
  output logic       ext_sel,
  output logic       reg_i_w_enable,
  output logic       reg_k_sel,
  output logic       reg_i_sel,
  output logic       alu_k_sel,
  output logic       ram_w_enable,
  output logic [1:0] func_sel,
  output logic       halted
);

  always_comb begin
    pc_write       = 1'b0;
    ir_write       = 1'b0;
    pc_sel         = 1'b0;
    ext_sel        = 1'b0;
    reg_i_w_enable = 1'b0;
    reg_k_sel      = 1'b0;
    reg_i_sel      = 1'b0;
    alu_k_sel      = 1'b0;
    ram_w_enable   = 1'b0;
    func_sel       = FUNC_IR;
    halted         = 1'b0;

    // en is rst_n: every output is quiet for as long as reset is held
    if (en) begin
      case (cur_state)
        ST_FETCH: ir_write = fetch_go;

        ST_EXEC: begin
          case (op)
            OP_R: begin
              func_sel  = FUNC_IR;
              alu_k_sel = 1'b0;
            end
            OP_ADDI, OP_LW, OP_SW: begin
              func_sel  = FUNC_ADD;
              alu_k_sel = 1'b1;
              ext_sel   = 1'b0;
            end
            OP_BEQ: begin
              func_sel = FUNC_SUB;
              alu_k_sel = 1'b0;
              pc_sel   = zero;
              pc_write = 1'b1;
            end
            OP_J: begin
              ext_sel  = 1'b1;
              pc_sel   = 1'b1;
              pc_write = 1'b1;
            end
            default: ;
          endcase
        end

        ST_MEM: begin
          // Address computation selects stay put for the whole RAM wait
          func_sel  = FUNC_ADD;
          alu_k_sel = 1'b1;
          // Store commits only in the cycle the RAM accepts it; PC advances with it
          if (op == OP_SW && mem_ready) begin
            ram_w_enable = 1'b1;
            pc_write     = 1'b1;
            pc_sel       = 1'b0;
          end
        end

        ST_WB: begin
          reg_i_w_enable = 1'b1;
          pc_write       = 1'b1;
          pc_sel         = 1'b0;
          reg_i_sel      = (op != OP_LW);                 // 0 = memory data
          reg_k_sel      = (op == OP_ADDI) || (op == OP_LW);
        end

        ST_HALT: halted = 1'b1;

        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Purpose: multi-cycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) with latched opcode.
// Latency: R/ADDI/SW 4 cycles, LW 5, BEQ/J 3 (mem_ready high); MEM stretches until mem_ready.
// Backpressure: mem_ready stalls MEM; with MC_CTRL_STEP_EN defined, step gates each FETCH.
// Ports: clk, rst_n (async, active-low), i_code[5:0], zero, mem_ready, step in;
//        datapath strobes/selects, func_sel[1:0], state[2:0], halted, illegal out.
// Build option: MC_CTRL_STEP_EN enables single-step FETCH gating; undefined, step is ignored.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] i_code,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       step,
  output logic       pc_write,
  output logic       ir_write,
  output logic       pc_sel,
  output logic       ext_sel,
  output logic       reg_i_w_enable,
  output logic       reg_k_sel,
  output logic       reg_i_sel,
  output logic       alu_k_sel,
  output logic       ram_w_enable,
  output logic [1:0] func_sel,
  output logic [2:0] state,
  output logic       halted,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic       illegal_q;
  logic       set_illegal;
  logic       fetch_go;

`ifdef MC_CTRL_STEP_EN
  assign fetch_go = step;
`else
  logic unused_step;
  assign unused_step = step;
  assign fetch_go    = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    case (state_q)
      ST_FETCH: if (fetch_go) state_d = ST_DECODE;

      // Routing uses the live i_code; op_q captures it on the same edge
      ST_DECODE: begin
        if (i_code == OP_HALT) begin
          state_d = ST_HALT;
        end else if (!op_is_exec(i_code)) begin
          state_d     = ST_HALT;
          set_illegal = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (op_q)
          OP_R, OP_ADDI: state_d = ST_WB;
          OP_LW, OP_SW:  state_d = ST_MEM;
          OP_BEQ, OP_J:  state_d = ST_FETCH;
          default: begin
            state_d     = ST_HALT;
            set_illegal = 1'b1;
          end
        endcase
      end

      ST_MEM: if (mem_ready) state_d = (op_q == OP_LW) ? ST_WB : ST_FETCH;

      ST_WB: state_d = ST_FETCH;

      ST_HALT: state_d = ST_HALT;

      // Codes 6/7 can only come from upset state; park safely and flag it
      default: begin
        state_d     = ST_HALT;
        set_illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) op_q <= i_code;
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  mc_ctrl_decode u_decode (
    .en             (rst_n),
    .cur_state      (state_q),
    .op             (op_q),
    .zero           (zero),
    .mem_ready      (mem_ready),
    .fetch_go       (fetch_go),
    .pc_write       (pc_write),
    .ir_write       (ir_write),
    .pc_sel         (pc_sel),
    .ext_sel        (ext_sel),
    .reg_i_w_enable (reg_i_w_enable),
    .reg_k_sel      (reg_k_sel),
    .reg_i_sel      (reg_i_sel),
    .alu_k_sel      (alu_k_sel),
    .ram_w_enable   (ram_w_enable),
    .func_sel       (func_sel),
    .halted         (halted)
  );

  assign state   = state_q;
  assign illegal = illegal_q;

endmodule
